// File: rtl/serdes_lb_pkg.sv
// Shared constants, enums and the LFSR step function for the SERDES loopback BIST.
package serdes_lb_pkg;

   localparam logic [7:0]  K28_5     = 8'hBC;
   localparam logic [7:0]  K23_7     = 8'hF7;
   localparam logic [15:0] CAFE_WORD = 16'hCAFE;
   localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
   // Feedback taps for x^32 + x^22 + x^2 + x + 1 (state bits 31, 21, 1, 0).
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      MODE_FIXED = 2'd0,
      MODE_COUNT = 2'd1,
      MODE_LFSR  = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {s[30:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/serdes_lb_pattern.sv
// Payload pattern source; one copy drives TX, a second predicts the expected RX payload.
module serdes_lb_pattern
   import serdes_lb_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              restart_i,
   input  logic              step_i,
   input  logic [1:0]        mode_i,
   output logic [DATA_W-1:0] pattern_o
);

   localparam int REP = (DATA_W + 31) / 32;

   logic [DATA_W-1:0]  cnt_q, cnt_d;
   logic [31:0]        lfsr_q, lfsr_d;
   logic [REP*32-1:0]  lfsr_rep_s;

   assign lfsr_rep_s = {REP{lfsr_q}};

   // next-state for counter and LFSR
   always_comb begin
      cnt_d  = cnt_q;
      lfsr_d = lfsr_q;
      if (restart_i) begin
         cnt_d  = '0;
         lfsr_d = LFSR_SEED;
      end else if (step_i) begin
         cnt_d  = cnt_q + DATA_W'(1);
         lfsr_d = lfsr_next(lfsr_q);
      end else begin
         cnt_d  = cnt_q;
         lfsr_d = lfsr_q;
      end
   end

   // pattern state registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q  <= '0;
         lfsr_q <= LFSR_SEED;
      end else begin
         cnt_q  <= cnt_d;
         lfsr_q <= lfsr_d;
      end
   end

   // payload selection; reserved mode behaves as fixed
   always_comb begin
      pattern_o = '0;
      case (mode_e'(mode_i))
         MODE_COUNT: pattern_o = cnt_q;
         MODE_LFSR:  pattern_o = lfsr_rep_s[DATA_W-1:0];
         default:    pattern_o = {(DATA_W/16){CAFE_WORD}};
      endcase
   end

endmodule

// File: rtl/serdes_lb_bist.sv
// SERDES loopback BIST: framed TX pattern generator plus RX checker with
// HUNT/CHECK/LOCKED lock tracking and saturating word/error counters.
module serdes_lb_bist
   import serdes_lb_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int FRAME_LEN   = 16,
   parameter int LOCK_FRAMES = 4,
   parameter int LOSS_ERRS   = 8,
   parameter int CNT_W       = 32
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  en_i,
   input  logic [1:0]            mode_i,
   input  logic                  clear_i,
   output logic [DATA_W-1:0]     tx_data_o,
   output logic [DATA_W/8-1:0]   tx_char_is_k_o,
   input  logic [DATA_W-1:0]     rx_data_i,
   input  logic [DATA_W/8-1:0]   rx_char_is_k_i,
   input  logic [DATA_W/8-1:0]   rx_not_in_table_i,
   input  logic [DATA_W/8-1:0]   rx_disp_err_i,
   output logic [1:0]            state_o,
   output logic                  locked_o,
   output logic                  err_o,
   output logic [CNT_W-1:0]      word_cnt_o,
   output logic [CNT_W-1:0]      err_cnt_o
);

   localparam int BYTES = DATA_W / 8;
   localparam int SEQ_W = DATA_W - 8;
   localparam int POS_W = $clog2(FRAME_LEN);
   localparam int LF_W  = $clog2(LOCK_FRAMES + 1);
   localparam int LE_W  = $clog2(LOSS_ERRS + 1);

   localparam logic [DATA_W-1:0] IDLE_WORD = DATA_W'({K23_7, K28_5});
   localparam logic [BYTES-1:0]  IDLE_K    = BYTES'(2'b11);
   localparam logic [BYTES-1:0]  COMMA_K   = BYTES'(1'b1);
   localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(FRAME_LEN - 1);

   // ---------------- generator ----------------
   logic              gen_active_q, gen_active_d;
   logic [POS_W-1:0]  gen_pos_q, gen_pos_d;
   logic [SEQ_W-1:0]  gen_seq_q, gen_seq_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic [BYTES-1:0]  tx_k_q, tx_k_d;
   logic              gen_restart_s, gen_step_s;
   logic [DATA_W-1:0] gen_pat_s;

   serdes_lb_pattern #(.DATA_W(DATA_W)) u_gen_pat (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .restart_i (gen_restart_s),
      .step_i    (gen_step_s),
      .mode_i    (mode_i),
      .pattern_o (gen_pat_s)
   );

   // en_i is only looked at between frames, so a started frame always completes
   always_comb begin
      gen_active_d  = gen_active_q;
      gen_pos_d     = gen_pos_q;
      gen_seq_d     = gen_seq_q;
      tx_data_d     = IDLE_WORD;
      tx_k_d        = IDLE_K;
      gen_restart_s = 1'b0;
      gen_step_s    = 1'b0;
      if (!gen_active_q) begin
         if (en_i) begin
            tx_data_d     = {gen_seq_q, K28_5};
            tx_k_d        = COMMA_K;
            gen_seq_d     = gen_seq_q + SEQ_W'(1);
            gen_restart_s = 1'b1;
            gen_active_d  = 1'b1;
            gen_pos_d     = POS_W'(1);
         end else begin
            tx_data_d = IDLE_WORD;
            tx_k_d    = IDLE_K;
         end
      end else begin
         tx_data_d  = gen_pat_s;
         tx_k_d     = '0;
         gen_step_s = 1'b1;
         if (gen_pos_q == LAST_POS) begin
            gen_active_d = 1'b0;
            gen_pos_d    = '0;
         end else begin
            gen_pos_d = gen_pos_q + POS_W'(1);
         end
      end
   end

   // generator registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         gen_active_q <= 1'b0;
         gen_pos_q    <= '0;
         gen_seq_q    <= '0;
         tx_data_q    <= IDLE_WORD;
         tx_k_q       <= IDLE_K;
      end else begin
         gen_active_q <= gen_active_d;
         gen_pos_q    <= gen_pos_d;
         gen_seq_q    <= gen_seq_d;
         tx_data_q    <= tx_data_d;
         tx_k_q       <= tx_k_d;
      end
   end

   assign tx_data_o      = tx_data_q;
   assign tx_char_is_k_o = tx_k_q;

   // ---------------- checker ----------------
   state_e            state_q, state_d;
   logic [POS_W-1:0]  chk_pos_q, chk_pos_d;
   logic [SEQ_W-1:0]  exp_seq_q, exp_seq_d;
   logic [LF_W-1:0]   frames_q, frames_d;
   logic [LE_W-1:0]   loss_q, loss_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d, err_cnt_q, err_cnt_d;
   logic              err_q, err_d, locked_q, locked_d;
   logic              chk_restart_s, chk_step_s, word_err_s, count_word_s;
   logic              rx_idle_s, rx_comma_s, rx_code_err_s;
   logic [SEQ_W-1:0]  rx_seq_s;
   logic [DATA_W-1:0] chk_pat_s;

   serdes_lb_pattern #(.DATA_W(DATA_W)) u_chk_pat (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .restart_i (chk_restart_s),
      .step_i    (chk_step_s),
      .mode_i    (mode_i),
      .pattern_o (chk_pat_s)
   );

   assign rx_idle_s     = (rx_data_i == IDLE_WORD) && (rx_char_is_k_i == IDLE_K);
   assign rx_comma_s    = (rx_data_i[7:0] == K28_5) && (rx_char_is_k_i == COMMA_K);
   assign rx_code_err_s = (|rx_not_in_table_i) || (|rx_disp_err_i);
   assign rx_seq_s      = rx_data_i[DATA_W-1:8];

   // lock state machine and word classification; idle words leave everything untouched
   always_comb begin
      state_d       = state_q;
      chk_pos_d     = chk_pos_q;
      exp_seq_d     = exp_seq_q;
      frames_d      = frames_q;
      loss_d        = loss_q;
      chk_restart_s = 1'b0;
      chk_step_s    = 1'b0;
      word_err_s    = 1'b0;
      count_word_s  = 1'b0;
      case (state_q)
         ST_HUNT: begin
            if (!rx_idle_s && rx_comma_s && !rx_code_err_s) begin
               exp_seq_d     = rx_seq_s + SEQ_W'(1);
               chk_pos_d     = POS_W'(1);
               chk_restart_s = 1'b1;
               frames_d      = '0;
               state_d       = ST_CHECK;
            end else begin
               state_d = ST_HUNT;
            end
         end
         ST_CHECK, ST_LOCKED: begin
            if (!rx_idle_s) begin
               if (chk_pos_q == '0) begin
                  word_err_s    = rx_code_err_s || !rx_comma_s || (rx_seq_s != exp_seq_q);
                  chk_restart_s = 1'b1;
                  exp_seq_d     = rx_seq_s + SEQ_W'(1);
               end else begin
                  word_err_s = rx_code_err_s || (|rx_char_is_k_i) || (rx_data_i != chk_pat_s);
                  chk_step_s = 1'b1;
               end
               chk_pos_d = (chk_pos_q == LAST_POS) ? '0 : chk_pos_q + POS_W'(1);
               if (state_q == ST_CHECK) begin
                  // a frame counts as clean once the following comma also checks out
                  if (word_err_s) begin
                     state_d = ST_HUNT;
                  end else if ((chk_pos_q == '0) && (frames_q == LF_W'(LOCK_FRAMES - 1))) begin
                     state_d = ST_LOCKED;
                     loss_d  = '0;
                  end else if (chk_pos_q == '0) begin
                     frames_d = frames_q + LF_W'(1);
                  end else begin
                     frames_d = frames_q;
                  end
               end else begin
                  count_word_s = 1'b1;
                  if (word_err_s && (loss_q == LE_W'(LOSS_ERRS - 1))) begin
                     state_d = ST_HUNT;
                     loss_d  = '0;
                  end else if (word_err_s) begin
                     loss_d = loss_q + LE_W'(1);
                  end else begin
                     loss_d = '0;
                  end
               end
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = ST_HUNT;
      endcase
   end

   // saturating counters; clear wins over a same-cycle increment
   always_comb begin
      word_cnt_d = word_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (clear_i) begin
         word_cnt_d = '0;
         err_cnt_d  = '0;
      end else begin
         if (count_word_s && (word_cnt_q != {CNT_W{1'b1}})) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
         end else begin
            word_cnt_d = word_cnt_q;
         end
         if (count_word_s && word_err_s && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end else begin
            err_cnt_d = err_cnt_q;
         end
      end
      err_d    = word_err_s;
      locked_d = (state_d == ST_LOCKED);
   end

   // checker registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_HUNT;
         chk_pos_q  <= '0;
         exp_seq_q  <= '0;
         frames_q   <= '0;
         loss_q     <= '0;
         word_cnt_q <= '0;
         err_cnt_q  <= '0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         chk_pos_q  <= chk_pos_d;
         exp_seq_q  <= exp_seq_d;
         frames_q   <= frames_d;
         loss_q     <= loss_d;
         word_cnt_q <= word_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_q      <= err_d;
         locked_q   <= locked_d;
      end
   end

   assign state_o    = state_q;
   assign locked_o   = locked_q;
   assign err_o      = err_q;
   assign word_cnt_o = word_cnt_q;
   assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_serdes_lb_bist.sv
// Self-checking bench: TX stream scoreboarded against a reference generator,
// checker behaviour verified with direct loopback plus injected faults.
module tb_serdes_lb_bist;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0;
   logic        clear = 1'b0;
   logic [1:0]  mode = 2'd1;
   logic [63:0] tx1, rx1, tx2, rx2;
   logic [63:0] flip1 = 64'h0;
   logic [63:0] flip2 = 64'h0;
   logic [7:0]  k1, k2;
   logic [7:0]  disp1 = 8'h00;
   logic [1:0]  st1, st2;
   logic        lk1, lk2, er1, er2;
   logic [31:0] wc1, ec1;
   logic [3:0]  wc2, ec2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign rx1 = tx1 ^ flip1;
   assign rx2 = tx2 ^ flip2;

   serdes_lb_bist #(.DATA_W(64), .FRAME_LEN(16), .LOCK_FRAMES(4), .LOSS_ERRS(8), .CNT_W(32)) u_dut (
      .clk_i(clk), .rstn_i(rstn), .en_i(en), .mode_i(mode), .clear_i(clear),
      .tx_data_o(tx1), .tx_char_is_k_o(k1),
      .rx_data_i(rx1), .rx_char_is_k_i(k1), .rx_not_in_table_i(8'h00), .rx_disp_err_i(disp1),
      .state_o(st1), .locked_o(lk1), .err_o(er1), .word_cnt_o(wc1), .err_cnt_o(ec1)
   );

   serdes_lb_bist #(.DATA_W(64), .FRAME_LEN(16), .LOCK_FRAMES(4), .LOSS_ERRS(8), .CNT_W(4)) u_dut_sat (
      .clk_i(clk), .rstn_i(rstn), .en_i(en), .mode_i(mode), .clear_i(clear),
      .tx_data_o(tx2), .tx_char_is_k_o(k2),
      .rx_data_i(rx2), .rx_char_is_k_i(k2), .rx_not_in_table_i(8'h00), .rx_disp_err_i(8'h00),
      .state_o(st2), .locked_o(lk2), .err_o(er2), .word_cnt_o(wc2), .err_cnt_o(ec2)
   );

   // Reference generator: pushes the expected TX word after every active edge.
   logic [71:0] sb_q[$];
   logic [71:0] sb_item;
   bit          m_active;
   int          m_pos, m_last_pos;
   logic [55:0] m_seq;
   logic [63:0] m_cnt, m_d;
   logic [31:0] m_lfsr;
   logic [7:0]  m_k, m_last_k;

   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         sb_q.delete();
         m_active = 1'b0; m_pos = 0; m_seq = 56'h0; m_last_k = 8'h03; m_last_pos = -1;
      end else begin
         if (!m_active) begin
            if (en) begin
               m_d = {m_seq, 8'hBC}; m_k = 8'h01; m_seq = m_seq + 56'h1;
               m_active = 1'b1; m_pos = 1; m_cnt = 64'h0; m_lfsr = 32'hFFFF_FFFF; m_last_pos = 0;
            end else begin
               m_d = 64'h0000_0000_0000_F7BC; m_k = 8'h03; m_last_pos = -1;
            end
         end else begin
            case (mode)
               2'd1:    m_d = m_cnt;
               2'd2:    m_d = {m_lfsr, m_lfsr};
               default: m_d = {4{16'hCAFE}};
            endcase
            m_k = 8'h00;
            m_cnt = m_cnt + 64'h1;
            m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
            m_last_pos = m_pos;
            if (m_pos == 15) begin m_active = 1'b0; m_pos = 0; end
            else m_pos = m_pos + 1;
         end
         m_last_k = m_k;
         sb_q.push_back({m_k, m_d});
      end
   end

   // Scoreboard monitor: pop and compare on the falling edge.
   initial forever begin
      @(negedge clk);
      if (rstn && sb_q.size() > 0) begin
         sb_item = sb_q.pop_front();
         checks++;
         if (tx1 !== sb_item[63:0] || k1 !== sb_item[71:64] || tx2 !== sb_item[63:0] || k2 !== sb_item[71:64]) begin
            failures++;
            $display("FAIL tx_word got=%h/%h sat=%h/%h exp=%h/%h", tx1, k1, tx2, k2, sb_item[63:0], sb_item[71:64]);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2;
      rstn = 1'b0; en = 1'b0; clear = 1'b0; flip1 = 64'h0; flip2 = 64'h0; disp1 = 8'h00;
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2 rstn = 1'b0; en = 1'b1;
      @(negedge clk);
      checks += 4;
      if (tx1 !== 64'h0000_0000_0000_F7BC) begin failures++; $display("FAIL reset_tx got=%h exp=%h", tx1, 64'h0000_0000_0000_F7BC); end
      if (k1 !== 8'h03) begin failures++; $display("FAIL reset_k got=%h exp=03", k1); end
      if (st1 !== 2'd0 || lk1 !== 1'b0 || er1 !== 1'b0) begin failures++; $display("FAIL reset_state got=%0d/%b/%b exp=0/0/0", st1, lk1, er1); end
      if (wc1 !== 32'h0 || ec1 !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", wc1, ec1); end
      do_reset();
   endtask

   task automatic test_lock();
      mode = 2'd1;
      @(negedge clk);
      en = 1'b1;
      repeat (65) @(negedge clk);
      checks++;
      if (st1 !== 2'd1) begin failures++; $display("FAIL lock_pre state got=%0d exp=1", st1); end
      @(negedge clk);
      checks += 3;
      if (st1 !== 2'd2 || lk1 !== 1'b1) begin failures++; $display("FAIL lock_state got=%0d/%b exp=2/1", st1, lk1); end
      if (wc1 !== 32'd0) begin failures++; $display("FAIL lock_wc0 got=%0d exp=0", wc1); end
      if (ec1 !== 32'd0) begin failures++; $display("FAIL lock_ec got=%0d exp=0", ec1); end
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         checks++;
         if (wc1 !== 32'(i) || ec1 !== 32'd0) begin failures++; $display("FAIL lock_wc_inc got=%0d/%0d exp=%0d/0", wc1, ec1, i); end
      end
   endtask

   task automatic test_bit_flip();
      int n = 0;
      @(negedge clk);
      while (!(m_last_k == 8'h00 && m_last_pos >= 3 && m_last_pos <= 10) && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (n >= 100) begin failures++; $display("FAIL flip_wait got=timeout exp=data_word"); end
      flip1 = 64'h20;
      @(negedge clk);
      flip1 = 64'h0;
      checks += 2;
      if (er1 !== 1'b1 || ec1 !== 32'd1) begin failures++; $display("FAIL flip_err got=%b/%0d exp=1/1", er1, ec1); end
      if (st1 !== 2'd2) begin failures++; $display("FAIL flip_lock got=%0d exp=2", st1); end
      @(negedge clk);
      checks++;
      if (er1 !== 1'b0 || lk1 !== 1'b1 || ec1 !== 32'd1) begin failures++; $display("FAIL flip_after got=%b/%b/%0d exp=0/1/1", er1, lk1, ec1); end
   endtask

   task automatic test_disp_loss();
      int n = 0;
      @(negedge clk);
      while (!(m_last_k == 8'h00 && m_last_pos >= 2) && n < 100) begin @(negedge clk); n++; end
      disp1 = 8'h01;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 7) begin
            checks++;
            if (st1 !== 2'd2) begin failures++; $display("FAIL loss_early got=%0d exp=2", st1); end
         end
      end
      disp1 = 8'h00;
      checks += 2;
      if (st1 !== 2'd0 || lk1 !== 1'b0) begin failures++; $display("FAIL loss_hunt got=%0d/%b exp=0/0", st1, lk1); end
      if (ec1 !== 32'd9) begin failures++; $display("FAIL loss_ec got=%0d exp=9", ec1); end
      n = 0;
      while (lk1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks += 2;
      if (lk1 !== 1'b1) begin failures++; $display("FAIL relock got=%b exp=1", lk1); end
      if (ec1 !== 32'd9) begin failures++; $display("FAIL relock_ec got=%0d exp=9", ec1); end
   endtask

   task automatic test_en_drop();
      int n = 0;
      logic [31:0] base;
      @(negedge clk);
      while (m_last_pos != 5 && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (n >= 40) begin failures++; $display("FAIL drop_wait got=timeout exp=pos5"); end
      base = wc1;
      en = 1'b0;
      repeat (30) @(negedge clk);
      checks += 2;
      if (wc1 !== base + 32'd11 || ec1 !== 32'd9) begin failures++; $display("FAIL drop_frozen got=%0d/%0d exp=%0d/9", wc1, ec1, base + 32'd11); end
      if (st1 !== 2'd2) begin failures++; $display("FAIL drop_lock got=%0d exp=2", st1); end
      en = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (ec1 !== 32'd9 || lk1 !== 1'b1) begin failures++; $display("FAIL reen got=%0d/%b exp=9/1", ec1, lk1); end
   endtask

   task automatic test_clear();
      int n = 0;
      @(negedge clk);
      while (!(m_last_k == 8'h00 && m_last_pos >= 2) && n < 100) begin @(negedge clk); n++; end
      flip1 = 64'h20;
      clear = 1'b1;
      @(negedge clk);
      flip1 = 64'h0;
      clear = 1'b0;
      checks += 2;
      if (er1 !== 1'b1 || wc1 !== 32'd0 || ec1 !== 32'd0) begin failures++; $display("FAIL clear_err got=%b/%0d/%0d exp=1/0/0", er1, wc1, ec1); end
      if (wc2 !== 4'd0 || ec2 !== 4'd0) begin failures++; $display("FAIL clear_sat got=%0d/%0d exp=0/0", wc2, ec2); end
      @(negedge clk);
      checks++;
      if (wc1 !== 32'd1 || ec1 !== 32'd0) begin failures++; $display("FAIL clear_next got=%0d/%0d exp=1/0", wc1, ec1); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         flip2 = (i % 2 == 0) ? 64'h20 : 64'h0;
      end
      @(negedge clk);
      flip2 = 64'h0;
      @(negedge clk);
      checks += 3;
      if (ec2 !== 4'hF) begin failures++; $display("FAIL sat_ec got=%h exp=f", ec2); end
      if (wc2 !== 4'hF || lk2 !== 1'b1) begin failures++; $display("FAIL sat_wc got=%h/%b exp=f/1", wc2, lk2); end
      if (ec1 !== 32'd0) begin failures++; $display("FAIL sat_other got=%0d exp=0", ec1); end
   endtask

   task automatic test_modes();
      int n = 0;
      do_reset();
      mode = 2'd0;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      checks++;
      if (tx1 !== 64'h0000_0000_0000_00BC || k1 !== 8'h01) begin failures++; $display("FAIL fixed_comma got=%h/%h exp=00000000000000bc/01", tx1, k1); end
      @(negedge clk);
      checks++;
      if (tx1 !== 64'hCAFE_CAFE_CAFE_CAFE || k1 !== 8'h00) begin failures++; $display("FAIL fixed_data got=%h/%h exp=cafecafecafecafe/00", tx1, k1); end
      repeat (5) @(negedge clk);
      do_reset();
      mode = 2'd2;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      checks++;
      if (tx1 !== 64'h0000_0000_0000_00BC) begin failures++; $display("FAIL lfsr_comma got=%h exp=00000000000000bc", tx1); end
      @(negedge clk);
      checks++;
      if (tx1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL lfsr_d0 got=%h exp=ffffffffffffffff", tx1); end
      @(negedge clk);
      checks++;
      if (tx1 !== 64'hFFFF_FFFE_FFFF_FFFE) begin failures++; $display("FAIL lfsr_d1 got=%h exp=fffffffefffffffe", tx1); end
      while (lk1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (lk1 !== 1'b1 || ec1 !== 32'd0) begin failures++; $display("FAIL lfsr_lock got=%b/%0d exp=1/0", lk1, ec1); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_bit_flip();
      test_disp_loss();
      test_en_drop();
      test_clear();
      test_saturate();
      test_modes();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serdes_lb_bist.md
# serdes_lb_bist

Parametrised built-in self-test for the SERDES loopback path, the successor to the fixed K28.5/CAFE loopback stimulus. It generates framed 8b/10b TX words in one of three payload modes, then checks the looped-back RX words. Checking covers framing, sequence numbers and payload. The block tracks lock through a HUNT/CHECK/LOCKED state machine and keeps saturating word and error counters. It sits between the `CC_SERDES` TX/RX data ports and the user logic. In the loopback top, `TX_CLK_I` and `RX_CLK_I` are both driven from `PLL_CLK_O`, with the RX buffer enabled, so the whole block runs on one clock.

## Interface
- `DATA_W`, default 64: datapath width; 16, 32 or 64; `BYTES = DATA_W/8`.
- `FRAME_LEN`, default 16: words per frame including the comma word; must be ≥2.
- `LOCK_FRAMES`, default 4: consecutive clean frames needed to go from CHECK to LOCKED.
- `LOSS_ERRS`, default 8: consecutive erroneous words that drop LOCKED to HUNT.
- `CNT_W`, default 32: width of both counters.
- `clk_i` in 1: the only clock.
- `rstn_i` in 1: asynchronous, active-low reset.
- `en_i` in 1: run the pattern; sampled only at frame boundaries.
- `mode_i` in 2: 0 fixed, 1 counter, 2 LFSR, 3 treated as fixed.
- `clear_i` in 1: synchronous clear of both counters.
- `tx_data_o` out `DATA_W`: to `TX_DATA_I`.
- `tx_char_is_k_o` out `BYTES`: to `TX_CHAR_IS_K_I`.
- `rx_data_i` in `DATA_W`: from `RX_DATA_O`.
- `rx_char_is_k_i`, `rx_not_in_table_i`, `rx_disp_err_i` in `BYTES` each.
- `state_o` out 2: 0 HUNT, 1 CHECK, 2 LOCKED.
- `locked_o` out 1: high while in LOCKED.
- `err_o` out 1: one-cycle pulse for each erroneous checked word.
- `word_cnt_o`, `err_cnt_o` out `CNT_W`: checked words and erroneous words while LOCKED.

## Operation
- **Idle word:** byte0 = K28.5 (`BC`), byte1 = K23.7 (`F7`), upper bytes `00`, k = `'b11`.
  - The checker ignores idle words completely: no state change, no counting, frame position held.
- **Comma word:** byte0 = K28.5 with k bit0 = 1; bytes above carry the frame sequence number (`DATA_W-8` bits, wrapping), with k bits = 0.
- **Data words:** positions 1 to `FRAME_LEN-1` in the frame; all k bits = 0. The pattern restarts at every comma:
  - fixed: `CAFE` replicated across the word, constant;
  - counter: starts at 0, +1 per data word, wraps at `2^DATA_W`;
  - LFSR: 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1, seed `FFFFFFFF`. Each data word carries the state replicated or truncated to `DATA_W`, then the LFSR steps once.
- **Generator:**
  - At each frame boundary, if `en_i`=1 it emits a comma word and starts a frame; otherwise it emits an idle word.
  - Once started, a frame always completes.
  - The sequence number increments per frame.
  - `mode_i` may change only while `en_i`=0, with the pipeline flushed (≥64 idle cycles).
- **Checker error conditions** (evaluated per non-idle word while in CHECK or LOCKED):
  - any `not_in_table` or `disp_err` bit set;
  - position 0 but not a comma word, or sequence ≠ previous+1;
  - position ≠0 and any k bit set, or payload ≠ predictor output.
- **State machine:**
  - HUNT: a comma word captures its sequence number, sets position to 1, restarts the predictor, and moves to CHECK.
  - CHECK: any error → HUNT. The word that caused the error is never reused as a comma. `LOCK_FRAMES` clean frames → LOCKED.
  - LOCKED: each checked word increments `word_cnt_o`; each erroneous word also increments `err_cnt_o`. The position and predictor keep advancing. `LOSS_ERRS` consecutive errors → HUNT; a clean word resets the run count.
- **Counters:** saturate at all-ones; `clear_i` has priority over a same-cycle increment.

## Timing
- All outputs are registered.
- Reset values: `tx_data_o` = idle word, `tx_char_is_k_o` = `'b11`, `state_o` = HUNT, `locked_o` = 0, `err_o` = 0, both counters = 0.
- First comma appears on `tx_data_o` one cycle after `en_i` is sampled high at a boundary.
- Checker latency: `err_o`, the counters and `state_o` update on the cycle after the RX word is presented.
- Reset mid-frame: everything returns to reset values immediately, and the generator restarts from sequence 0.

## Structure
- Package `serdes_lb_pkg`:
  - K-code constants (K28.5, K23.7);
  - mode and state enums;
  - LFSR polynomial and seed;
  - `CAFE` constant.
- Sub-module `serdes_lb_pattern`, with inputs restart/step and a `DATA_W` output. It is instantiated twice: once as the TX generator and once as the checker predictor.

## Test plan
- Reset → `tx_data_o` = `...F7BC`, k = `'b11`, `state_o` = 0, counters = 0.
- `DATA_W`=64, `FRAME_LEN`=16, mode 1, direct loopback with `en_i`=1 → LOCKED after 1 + 4×16 RX words; `err_cnt_o` stays 0 and `word_cnt_o` increments each cycle.
- Flip bit 5 of one data word while LOCKED → single `err_o` pulse; `err_cnt_o` = 1; lock kept.
- Force `rx_disp_err_i` = `01` for 8 consecutive words → HUNT and `locked_o` = 0; relock after 4 clean frames.
- Drop `en_i` mid-frame → frame completes, then idle words; checker stays LOCKED with counters frozen; re-enable → sequence continues +1 with no error.
- `clear_i` together with an error → counters read 0; saturation check with `CNT_W`=4: 20 errors → `err_cnt_o` = `F`.
